// File: rtl/rol_seq_32_if.sv
// Request/result bundle for the sequential rotate unit.
// Optional dir signal exists only when ROL_BIDIR_EN is defined.
interface rol_seq_32_if;
    logic        start;
    logic [31:0] rIn;
    logic [31:0] rotB;
`ifdef ROL_BIDIR_EN
    logic        dir;
`endif
    logic [31:0] rOut;
    logic        busy;
    logic        done;

    modport master (
        output start, rIn, rotB,
`ifdef ROL_BIDIR_EN
        output dir,
`endif
        input  rOut, busy, done
    );

    modport slave (
        input  start, rIn, rotB,
`ifdef ROL_BIDIR_EN
        input  dir,
`endif
        output rOut, busy, done
    );
endinterface

// File: rtl/rol_seq_32.sv
// Iterative 32-bit rotate, up to STEP bits per clock, done pulse on finish.
// Ports: clock, clear (async active-low), bus (slave). Macro: ROL_BIDIR_EN.
module rol_seq_32 #(
    parameter int unsigned STEP = 1
) (
    input  logic   clock,
    input  logic   clear,
    rol_seq_32_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rout_q, rout_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [5:0]  k;
    logic [31:0] rot;
`ifdef ROL_BIDIR_EN
    logic        dir_q, dir_d;
`endif

    // Step size for this cycle: never overshoot the remaining count.
    assign k = (cnt_q > STEP_W) ? STEP_W : cnt_q;

`ifdef ROL_BIDIR_EN
    assign rot = dir_q
        ? ((data_q >> k) | (data_q << (6'd32 - k)))
        : ((data_q << k) | (data_q >> (6'd32 - k)));
`else
    assign rot = (data_q << k) | (data_q >> (6'd32 - k));
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (cnt_q == 6'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        rout_d = rout_q;
        done_d = 1'b0;
`ifdef ROL_BIDIR_EN
        dir_d  = dir_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d = bus.rIn;
                    cnt_d  = 6'(bus.rotB % 32'd32);
`ifdef ROL_BIDIR_EN
                    dir_d  = bus.dir;
`endif
                end
            end
            RUN: begin
                if (cnt_q != 6'd0) begin
                    data_d = rot;
                    cnt_d  = cnt_q - k;
                end else begin
                    rout_d = data_q;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            data_q <= '0;
            cnt_q  <= '0;
            rout_q <= '0;
            done_q <= 1'b0;
`ifdef ROL_BIDIR_EN
            dir_q  <= 1'b0;
`endif
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            rout_q <= rout_d;
            done_q <= done_d;
`ifdef ROL_BIDIR_EN
            dir_q  <= dir_d;
`endif
        end
    end

    // busy tracks RUN exactly: set on the accepting edge, cleared with done.
    assign bus.rOut = rout_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
endmodule

// File: tb/tb_rol_seq_32.sv
// Bench for rol_seq_32: three step sizes side by side against a
// latency/result model, plus directed literal checks.
module tb_rol_seq_32;
    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] r_in;
    logic [31:0] rot_b;
    logic        dir;

    int errors;
    int checks;

    rol_seq_32_if if0 ();
    rol_seq_32_if if1 ();
    rol_seq_32_if if2 ();

    assign if0.start = start;
    assign if0.rIn   = r_in;
    assign if0.rotB  = rot_b;
    assign if1.start = start;
    assign if1.rIn   = r_in;
    assign if1.rotB  = rot_b;
    assign if2.start = start;
    assign if2.rIn   = r_in;
    assign if2.rotB  = rot_b;
`ifdef ROL_BIDIR_EN
    assign if0.dir = dir;
    assign if1.dir = dir;
    assign if2.dir = dir;
`endif

    rol_seq_32 #(.STEP(1))  u0 (.clock(clock), .clear(clear), .bus(if0.slave));
    rol_seq_32 #(.STEP(4))  u1 (.clock(clock), .clear(clear), .bus(if1.slave));
    rol_seq_32 #(.STEP(32)) u2 (.clock(clock), .clear(clear), .bus(if2.slave));

    logic [31:0] rout_w [3];
    logic        busy_w [3];
    logic        done_w [3];

    assign rout_w[0] = if0.rOut;
    assign rout_w[1] = if1.rOut;
    assign rout_w[2] = if2.rOut;
    assign busy_w[0] = if0.busy;
    assign busy_w[1] = if1.busy;
    assign busy_w[2] = if2.busy;
    assign done_w[0] = if0.done;
    assign done_w[1] = if1.done;
    assign done_w[2] = if2.done;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- model ----------------
    function automatic int step_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 4 : 32);
    endfunction

    function automatic int lat_of(input int i, input logic [31:0] amt);
        int n;
        n = int'(amt % 32);
        return (n + step_of(i) - 1) / step_of(i) + 1;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} << (n % 32);
        return t[63:32];
    endfunction

    function automatic logic [31:0] expect_of(input logic [31:0] x,
                                              input logic [31:0] amt,
                                              input logic d);
        int n;
        n = int'(amt % 32);
        return d ? rotl(x, (32 - n) % 32) : rotl(x, n);
    endfunction

    int          rem      [3];
    logic [31:0] pend     [3];
    logic [31:0] exp_rout [3];
    logic        exp_done [3];
    logic        prev_done[3];

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 3; i++) begin
                rem[i]      <= 0;
                pend[i]     <= '0;
                exp_rout[i] <= '0;
                exp_done[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0) begin
                    exp_done[i] <= 1'b0;
                    if (start) begin
                        rem[i]  <= lat_of(i, rot_b);
                        pend[i] <= expect_of(r_in, rot_b, dir);
                    end
                end else begin
                    rem[i] <= rem[i] - 1;
                    if (rem[i] == 1) begin
                        exp_done[i] <= 1'b1;
                        exp_rout[i] <= pend[i];
                    end else begin
                        exp_done[i] <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) prev_done[i] = 1'b0;
    end

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rout%0d", i), rout_w[i], exp_rout[i]);
            chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(rem[i] != 0));
            chk($sformatf("done%0d", i), 32'(done_w[i]), 32'(exp_done[i]));
            chk($sformatf("done2x%0d", i),
                32'(prev_done[i] && done_w[i]), 32'd0);
            prev_done[i] = done_w[i];
        end
    end

    // ---------------- directed ----------------
    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input logic d, input logic [31:0] exp,
                      input int l0, input int l1, input int l2,
                      input bit noise);
        int lt [3];
        bit seen [3];
        lt[0] = l0;
        lt[1] = l1;
        lt[2] = l2;
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
        @(negedge clock);
        start = 1'b1;
        r_in  = a;
        rot_b = b;
        dir   = d;
        @(posedge clock);
        #1;
        if (noise) begin
            r_in  = 32'hFFFF0000;
            rot_b = 32'd7;
        end else begin
            start = 1'b0;
            r_in  = ~a;
            rot_b = b + 32'd5;
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (done_w[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    chk($sformatf("lat%0d", i), 32'(c), 32'(lt[i]));
                    chk($sformatf("res%0d", i), rout_w[i], exp);
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
        end
        for (int i = 0; i < 3; i++) begin
            if (!seen[i]) begin
                checks++;
                errors++;
                $display("FAIL timeout%0d: no done, want latency %0d",
                         i, lt[i]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear  = 1'b0;
        start  = 1'b0;
        r_in   = '0;
        rot_b  = '0;
        dir    = 1'b0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_rout%0d", i), rout_w[i], 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("rst_done%0d", i), 32'(done_w[i]), 32'd0);
        end
        clear = 1'b1;
        @(negedge clock);

        op(32'h80000001, 32'd1,  1'b0, 32'h00000003, 2, 2, 2, 1'b0);
        op(32'h12345678, 32'd4,  1'b0, 32'h23456781, 5, 2, 2, 1'b0);
        op(32'hDEADBEEF, 32'd0,  1'b0, 32'hDEADBEEF, 1, 1, 1, 1'b0);
        op(32'h12345678, 32'd36, 1'b0, 32'h23456781, 5, 2, 2, 1'b0);
        op(32'h00000001, 32'd31, 1'b0, 32'h80000000, 32, 9, 2, 1'b0);
        op(32'hA5A5A5A5, 32'd33, 1'b0, 32'h4B4B4B4B, 2, 2, 2, 1'b0);
        op(32'h0000000F, 32'd8,  1'b0, 32'h00000F00, 9, 3, 2, 1'b1);
`ifdef ROL_BIDIR_EN
        op(32'h12345678, 32'd4,  1'b1, 32'h81234567, 5, 2, 2, 1'b0);
        op(32'h00000001, 32'd1,  1'b1, 32'h80000000, 2, 2, 2, 1'b0);
`endif

        // Continuous start: back-to-back accepts in done cycles,
        // ignored requests while busy.
        for (int j = 0; j < 60; j++) begin
            @(negedge clock);
            start = 1'b1;
            r_in  = $urandom;
            rot_b = $urandom;
`ifdef ROL_BIDIR_EN
            dir   = 1'($urandom_range(0, 1));
`else
            dir   = 1'b0;
`endif
        end
        @(negedge clock);
        start = 1'b0;
        dir   = 1'b0;
        repeat (40) @(negedge clock);

        // Asynchronous clear in the middle of a long rotation.
        @(negedge clock);
        start = 1'b1;
        r_in  = 32'h00000001;
        rot_b = 32'd31;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("clr_rout%0d", i), rout_w[i], 32'd0);
            chk($sformatf("clr_busy%0d", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("clr_done%0d", i), 32'(done_w[i]), 32'd0);
        end
        repeat (2) @(negedge clock);
        clear = 1'b1;
        repeat (40) @(negedge clock);
        op(32'h12345678, 32'd4, 1'b0, 32'h23456781, 5, 2, 2, 1'b0);
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
